axi4_lite_master: RTL and testbench
===================================

// Module: axi4_lite_master
// PURPOSE
//  AXI4-Lite manager: converts one CPU-side request (IFU fetch or LSU load/store) into AXI4-Lite
//  AR/R or AW/W/B transactions toward a subordinate, and returns a single response to the CPU.
//  Sits between the core's memory stage and the bus/arbiter. One outstanding transaction at a time.
// PARAMETERS
//  ADDR_W     32   address width (AR/AW addr, iReqAddr)
//  DATA_W     32   data width (R/W data, request/response data)
//  MASK_W      4   write strobe width, = DATA_W/8
//  RESP_W      2   AXI response width
//  TIMEOUT_CYC 255 cycles allowed per transaction before abort (used only with AXI4_LITE_M_TIMEOUT_EN)
// PORTS
//  iClock              in   1       clock, rising edge
//  iResetN             in   1       asynchronous, active-low reset
//  iReqValid           in   1       CPU request valid
//  iReqWr              in   1       1 = write, 0 = read
//  iReqAddr            in   ADDR_W  request address
//  iReqData            in   DATA_W  write data
//  iReqMask            in   MASK_W  write strobes
//  oReqReady           out  1       request accepted when iReqValid && oReqReady
//  oRspValid           out  1       response valid
//  oRspData            out  DATA_W  read data (0 for writes)
//  oRspResp            out  RESP_W  AXI response (rresp/bresp, or 2'b11 on timeout)
//  iRspReady           in   1       CPU accepts response
//  oTimeout            out  1       1-cycle pulse when a transaction is aborted
//  pAXI4_ar_valid/ar_bits_addr out 1/ADDR_W;  pAXI4_ar_ready in 1
//  pAXI4_r_ready out 1;  pAXI4_r_valid in 1;  pAXI4_r_bits_data in DATA_W;  pAXI4_r_bits_resp in RESP_W
//  pAXI4_aw_valid/aw_bits_addr out 1/ADDR_W;  pAXI4_aw_ready in 1
//  pAXI4_w_valid/w_bits_data/w_bits_strb out 1/DATA_W/MASK_W;  pAXI4_w_ready in 1
//  pAXI4_b_ready out 1;  pAXI4_b_valid in 1;  pAXI4_b_bits_resp in RESP_W
// BEHAVIOUR
//  - Reset (iResetN=0, async): state IDLE; all valid/ready outputs 0 except oReqReady=1;
//    addr/data/strb/rsp registers 0; oTimeout 0; timeout counter 0.
//  - oReqReady = (state==IDLE). Request fields latched on the accept edge; AXI outputs driven
//    only from registers, held stable while the corresponding valid is high.
//  - FSM: IDLE -> RD_ADDR | WR_REQ on accept (decided by iReqWr).
//    RD_ADDR: ar_valid=1; on ar handshake -> RD_DATA (ar_valid 0 next cycle).
//    RD_DATA: r_ready=1; on r handshake latch rdata/rresp -> RSP.
//    WR_REQ: aw_valid and w_valid both asserted on entry; each drops independently after its own
//      handshake; leave for WR_RESP once both done (same-cycle handshakes allowed).
//    WR_RESP: b_ready=1; on b handshake latch bresp, oRspData=0 -> RSP.
//    RSP: oRspValid=1 until iRspReady; then -> IDLE.
//  - Latency: accept at edge N -> ar_valid/aw_valid high in cycle N+1; zero-wait subordinate gives
//    oRspValid in cycle N+3 (read) or N+3 (write, AW/W same cycle).
//  - Never asserts ar_valid and aw_valid together; no new request accepted until RSP handshake.
//  - Valids never withdrawn before handshake (AXI rule), except on timeout abort.
//  - iReqValid while busy: ignored, not queued. Reset mid-transaction: all AXI valids drop
//    immediately (async), transaction lost, no response issued.
// CONFIGURATION
//  AXI4_LITE_M_TIMEOUT_EN defined: counter clears on accept, increments each cycle in
//   RD_ADDR/RD_DATA/WR_REQ/WR_RESP; at TIMEOUT_CYC all AXI valids/readies drop next edge,
//   oRspResp=2'b11, oRspData=0, oTimeout pulses 1 cycle, -> RSP.
//  Undefined: no counter; waits indefinitely; oTimeout tied 0.
// TESTING
//  Read, zero-wait: req addr 0x8000_0000 rd; ar_ready=1, r_valid next, rdata 0xDEADBEEF resp 0 ->
//   oRspValid cycle N+3, oRspData 0xDEADBEEF, oRspResp 0.
//  Write, W before AW: addr 0x8000_0010 data 0x1234_5678 mask 4'b0011; w_ready at N+1, aw_ready
//   at N+4 -> w_valid drops N+2, aw_valid held to N+4, then b_ready; bresp 0 -> oRspResp 0, data 0.
//  Backpressure: r_valid held, iRspReady low 5 cycles -> oRspValid/oRspData stable; oReqReady 0.
//  Error response: bresp 2'b10 -> oRspResp 2'b10 returned unchanged.
//  Timeout (macro on, TIMEOUT_CYC=8): ar_ready never -> ar_valid drops after 8 cycles,
//   oTimeout 1 pulse, oRspResp 2'b11; macro off -> ar_valid stays high for 100 cycles.
//  Async reset during WR_REQ: iResetN low mid-cycle -> aw/w_valid 0 without clock, oReqReady 1 after release.

Source files
------------

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master
// Function : Converts one CPU request at a time into AXI4-Lite AR/R or AW/W/B
//            transactions and returns a single response to the CPU.
//            Optional transaction abort: define AXI4_LITE_M_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MASK_W      = DATA_W / 8,
    parameter int RESP_W      = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              iClock,
    input  logic              iResetN,
    // CPU request / response
    input  logic              iReqValid,
    input  logic              iReqWr,
    input  logic [ADDR_W-1:0] iReqAddr,
    input  logic [DATA_W-1:0] iReqData,
    input  logic [MASK_W-1:0] iReqMask,
    output logic              oReqReady,
    output logic              oRspValid,
    output logic [DATA_W-1:0] oRspData,
    output logic [RESP_W-1:0] oRspResp,
    input  logic              iRspReady,
    output logic              oTimeout,
    // AXI4-Lite read address / data
    output logic              pAXI4_ar_valid,
    output logic [ADDR_W-1:0] pAXI4_ar_bits_addr,
    input  logic              pAXI4_ar_ready,
    output logic              pAXI4_r_ready,
    input  logic              pAXI4_r_valid,
    input  logic [DATA_W-1:0] pAXI4_r_bits_data,
    input  logic [RESP_W-1:0] pAXI4_r_bits_resp,
    // AXI4-Lite write address / data / response
    output logic              pAXI4_aw_valid,
    output logic [ADDR_W-1:0] pAXI4_aw_bits_addr,
    input  logic              pAXI4_aw_ready,
    output logic              pAXI4_w_valid,
    output logic [DATA_W-1:0] pAXI4_w_bits_data,
    output logic [MASK_W-1:0] pAXI4_w_bits_strb,
    input  logic              pAXI4_w_ready,
    output logic              pAXI4_b_ready,
    input  logic              pAXI4_b_valid,
    input  logic [RESP_W-1:0] pAXI4_b_bits_resp
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RSP     = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                ar_valid_q, ar_valid_d;
    logic                r_ready_q, r_ready_d;
    logic                aw_valid_q, aw_valid_d;
    logic                w_valid_q, w_valid_d;
    logic                b_ready_q, b_ready_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MASK_W-1:0]   strb_q, strb_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [RESP_W-1:0]   rsp_resp_q, rsp_resp_d;

    logic                ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic                aw_done, w_done;

`ifdef AXI4_LITE_M_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                timeout_q, timeout_d;
    logic                busy;

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_RSP);
    assign oTimeout = timeout_q;
`else
    logic                unused_tmo_cfg;

    assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
    assign oTimeout       = 1'b0;
`endif

    assign ar_hs   = ar_valid_q && pAXI4_ar_ready;
    assign r_hs    = r_ready_q  && pAXI4_r_valid;
    assign aw_hs   = aw_valid_q && pAXI4_aw_ready;
    assign w_hs    = w_valid_q  && pAXI4_w_ready;
    assign b_hs    = b_ready_q  && pAXI4_b_valid;
    // A channel is finished once its valid is gone or it handshakes this cycle
    assign aw_done = !aw_valid_q || aw_hs;
    assign w_done  = !w_valid_q  || w_hs;

    always_comb begin
        state_d     = state_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef AXI4_LITE_M_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (iReqValid) begin
                    addr_d = iReqAddr;
                    data_d = iReqData;
                    strb_d = iReqMask;
`ifdef AXI4_LITE_M_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (iReqWr) begin
                        state_d    = ST_WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = ST_RD_ADDR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (r_hs) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = pAXI4_r_bits_data;
                    rsp_resp_d  = pAXI4_r_bits_resp;
                    state_d     = ST_RSP;
                end
            end
            ST_WR_REQ: begin
                if (aw_hs) aw_valid_d = 1'b0;
                if (w_hs)  w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    b_ready_d = 1'b1;
                    state_d   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (b_hs) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_resp_d  = pAXI4_b_bits_resp;
                    state_d     = ST_RSP;
                end
            end
            ST_RSP: begin
                if (iRspReady) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef AXI4_LITE_M_TIMEOUT_EN
        // Abort wins over any handshake landing in the final allowed cycle
        if (busy) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
            if (tmo_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                ar_valid_d  = 1'b0;
                r_ready_d   = 1'b0;
                aw_valid_d  = 1'b0;
                w_valid_d   = 1'b0;
                b_ready_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_resp_d  = {RESP_W{1'b1}};
                timeout_d   = 1'b1;
                state_d     = ST_RSP;
            end
        end
`endif
    end

    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q     <= ST_IDLE;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            strb_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_resp_q  <= '0;
`ifdef AXI4_LITE_M_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef AXI4_LITE_M_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign oReqReady          = (state_q == ST_IDLE);
    assign oRspValid          = rsp_valid_q;
    assign oRspData           = rsp_data_q;
    assign oRspResp           = rsp_resp_q;
    assign pAXI4_ar_valid     = ar_valid_q;
    assign pAXI4_ar_bits_addr = addr_q;
    assign pAXI4_r_ready      = r_ready_q;
    assign pAXI4_aw_valid     = aw_valid_q;
    assign pAXI4_aw_bits_addr = addr_q;
    assign pAXI4_w_valid      = w_valid_q;
    assign pAXI4_w_bits_data  = data_q;
    assign pAXI4_w_bits_strb  = strb_q;
    assign pAXI4_b_ready      = b_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master
// Function : Bench for axi4_lite_master: memory-backed subordinate with random
//            ready/valid delays and a word-level reference memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_lite_master;

    localparam int TMO = 8;

    logic        clk, rst_n;
    logic        req_valid, req_wr, req_ready;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_mask;
    logic        rsp_valid, rsp_ready, timeout;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_resp;
    logic        ar_valid, ar_ready, r_ready, r_valid;
    logic [31:0] ar_addr, r_data;
    logic [1:0]  r_resp;
    logic        aw_valid, aw_ready, w_valid, w_ready, b_ready, b_valid;
    logic [31:0] aw_addr, w_data;
    logic [3:0]  w_strb;
    logic [1:0]  b_resp;

    axi4_lite_master #(.TIMEOUT_CYC(TMO)) dut (
        .iClock(clk), .iResetN(rst_n),
        .iReqValid(req_valid), .iReqWr(req_wr), .iReqAddr(req_addr),
        .iReqData(req_data), .iReqMask(req_mask), .oReqReady(req_ready),
        .oRspValid(rsp_valid), .oRspData(rsp_data), .oRspResp(rsp_resp),
        .iRspReady(rsp_ready), .oTimeout(timeout),
        .pAXI4_ar_valid(ar_valid), .pAXI4_ar_bits_addr(ar_addr), .pAXI4_ar_ready(ar_ready),
        .pAXI4_r_ready(r_ready), .pAXI4_r_valid(r_valid),
        .pAXI4_r_bits_data(r_data), .pAXI4_r_bits_resp(r_resp),
        .pAXI4_aw_valid(aw_valid), .pAXI4_aw_bits_addr(aw_addr), .pAXI4_aw_ready(aw_ready),
        .pAXI4_w_valid(w_valid), .pAXI4_w_bits_data(w_data), .pAXI4_w_bits_strb(w_strb),
        .pAXI4_w_ready(w_ready),
        .pAXI4_b_ready(b_ready), .pAXI4_b_valid(b_valid), .pAXI4_b_bits_resp(b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // subordinate configuration and state
    int ar_dly, aw_dly, w_dly, r_dly, b_dly, rsp_dly;
    logic [1:0] cfg_resp;
    int ar_cnt, aw_cnt, w_cnt, r_wait, b_wait, rsp_cnt;
    bit r_pend, b_pend, aw_got, w_got;
    logic [31:0] cap_ar_addr, cap_aw_addr, cap_w_data;
    logic [3:0]  cap_w_strb;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];

    // observations
    int cyc = 0;
    int acc_cyc, ar_first, ar_last, aw_first, aw_last, w_first, w_last, b_first;
    int rsp_first, got_cyc, to_cyc, to_cnt, ar_hi, proto_err;
    int ar_hs, aw_hs, w_hs, r_hs, b_hs;
    bit got;
    logic [31:0] got_data;
    logic [1:0]  got_resp;
    logic p_ar_v, p_ar_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_rsp_v, p_rsp_r;
    logic [31:0] p_ar_a, p_aw_a, p_w_d, p_rsp_d;
    logic [3:0]  p_w_s;
    logic [1:0]  p_rsp_resp;

    task automatic sub_clear();
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
        ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_wait = 0; b_wait = 0; rsp_cnt = 0;
        ar_ready = 0; r_valid = 0; r_data = 0; r_resp = 0;
        aw_ready = 0; w_ready = 0; b_valid = 0; b_resp = 0; rsp_ready = 0;
        p_ar_v = 0; p_ar_r = 0; p_aw_v = 0; p_aw_r = 0; p_w_v = 0; p_w_r = 0;
        p_rsp_v = 0; p_rsp_r = 0;
    endtask

    // One clock: observe DUT at the falling edge, then drive subordinate/CPU inputs.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (ar_valid && aw_valid) proto_err++;
        if (req_ready && (ar_valid || aw_valid || w_valid || r_ready || b_ready || rsp_valid))
            proto_err++;
        if (!timeout) begin
            if (p_ar_v && !p_ar_r && (!ar_valid || ar_addr !== p_ar_a)) proto_err++;
            if (p_aw_v && !p_aw_r && (!aw_valid || aw_addr !== p_aw_a)) proto_err++;
            if (p_w_v && !p_w_r && (!w_valid || w_data !== p_w_d || w_strb !== p_w_s)) proto_err++;
        end
        if (p_rsp_v && !p_rsp_r &&
            (!rsp_valid || rsp_data !== p_rsp_d || rsp_resp !== p_rsp_resp)) proto_err++;
        if (timeout) begin to_cnt++; to_cyc = cyc; end
        if (ar_valid) begin if (ar_first < 0) ar_first = cyc; ar_last = cyc; ar_hi++; end
        if (aw_valid) begin if (aw_first < 0) aw_first = cyc; aw_last = cyc; end
        if (w_valid)  begin if (w_first < 0) w_first = cyc; w_last = cyc; end
        if (b_ready && b_first < 0) b_first = cyc;
        if (rsp_valid && rsp_first < 0) rsp_first = cyc;

        r_valid = 0; r_data = 0; r_resp = 0;
        if (r_pend) begin
            if (r_wait >= r_dly) begin
                r_valid = 1; r_data = mem[cap_ar_addr[5:2]]; r_resp = cfg_resp;
                if (r_ready) begin r_pend = 0; r_hs++; end
            end else r_wait++;
        end
        ar_ready = 0;
        if (ar_valid) begin
            if (ar_cnt >= ar_dly) begin
                ar_ready = 1; cap_ar_addr = ar_addr; r_pend = 1; r_wait = 0; ar_cnt = 0; ar_hs++;
            end else ar_cnt++;
        end else ar_cnt = 0;

        b_valid = 0; b_resp = 0;
        if (b_pend) begin
            if (b_wait >= b_dly) begin
                b_valid = 1; b_resp = cfg_resp;
                if (b_ready) begin b_pend = 0; b_hs++; end
            end else b_wait++;
        end
        aw_ready = 0; w_ready = 0;
        if (aw_valid) begin
            if (aw_cnt >= aw_dly) begin
                aw_ready = 1; cap_aw_addr = aw_addr; aw_got = 1; aw_cnt = 0; aw_hs++;
            end else aw_cnt++;
        end else aw_cnt = 0;
        if (w_valid) begin
            if (w_cnt >= w_dly) begin
                w_ready = 1; cap_w_data = w_data; cap_w_strb = w_strb; w_got = 1; w_cnt = 0; w_hs++;
            end else w_cnt++;
        end else w_cnt = 0;
        if (aw_got && w_got) begin
            for (int b = 0; b < 4; b++)
                if (cap_w_strb[b]) mem[cap_aw_addr[5:2]][8*b +: 8] = cap_w_data[8*b +: 8];
            aw_got = 0; w_got = 0; b_pend = 1; b_wait = 0;
        end

        rsp_ready = 0;
        if (rsp_valid) begin
            if (rsp_cnt >= rsp_dly) begin
                rsp_ready = 1; got = 1; got_cyc = cyc; got_data = rsp_data; got_resp = rsp_resp;
                rsp_cnt = 0;
            end else rsp_cnt++;
        end else rsp_cnt = 0;

        p_ar_v = ar_valid; p_ar_r = ar_ready; p_ar_a = ar_addr;
        p_aw_v = aw_valid; p_aw_r = aw_ready; p_aw_a = aw_addr;
        p_w_v = w_valid; p_w_r = w_ready; p_w_d = w_data; p_w_s = w_strb;
        p_rsp_v = rsp_valid; p_rsp_r = rsp_ready; p_rsp_d = rsp_data; p_rsp_resp = rsp_resp;
    endtask

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input bit hold, output bit ok);
        int n;
        ar_first = -1; ar_last = -1; aw_first = -1; aw_last = -1; w_first = -1; w_last = -1;
        b_first = -1; rsp_first = -1; got_cyc = -1; to_cyc = -1;
        to_cnt = 0; ar_hi = 0; ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0; got = 0;
        req_valid = 1; req_wr = wr; req_addr = a; req_data = d; req_mask = m;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin tick(); n++; end
        ok = (req_ready === 1'b1);
        acc_cyc = cyc;
        tick();
        if (hold) begin req_wr = ~wr; req_addr = a ^ 32'h40; end
        else req_valid = 0;
    endtask

    task automatic wait_rsp(input int budget, output bit ok);
        int n = 0;
        while (!got && n < budget) begin tick(); n++; end
        ok = got;
    endtask

    task automatic set_dly(input int a, input int aw, input int w, input int r,
                           input int b, input int rs);
        ar_dly = a; aw_dly = aw; w_dly = w; r_dly = r; b_dly = b; rsp_dly = rs;
    endtask

    task automatic test_reset();
        rst_n = 0; req_valid = 0; req_wr = 0; req_addr = 0; req_data = 0; req_mask = 0;
        sub_clear(); set_dly(0, 0, 0, 0, 0, 0); cfg_resp = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hA5A5_A5A5 ^ (i * 32'h0101_0101);
            ref_mem[i] = mem[i];
        end
        tick(); tick();
        vectors++;
        if ({req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, timeout} !== 8'h80) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 10000000",
                     {req_ready, ar_valid, aw_valid, w_valid, r_ready, b_ready, rsp_valid, timeout});
        end
        vectors++;
        if ({rsp_data, rsp_resp} !== 34'd0) begin
            miscompares++; $display("FAIL reset_rsp: got %h/%h expected 0/0", rsp_data, rsp_resp);
        end
        vectors++;
        if ({ar_addr, aw_addr, w_data, w_strb} !== 100'd0) begin
            miscompares++;
            $display("FAIL reset_regs: got ar=%h aw=%h w=%h s=%h expected zeros", ar_addr, aw_addr, w_data, w_strb);
        end
        rst_n = 1;
        tick();
        vectors++;
        if (req_ready !== 1'b1 || ar_valid !== 1'b0) begin
            miscompares++; $display("FAIL post_reset: got ready=%b ar=%b expected 1/0", req_ready, ar_valid);
        end
    endtask

    task automatic test_read_zero_wait();
        bit ok, ok2;
        mem[0] = 32'hDEAD_BEEF; ref_mem[0] = 32'hDEAD_BEEF;
        set_dly(0, 0, 0, 0, 0, 0); cfg_resp = 2'b00; proto_err = 0;
        issue(0, 32'h8000_0000, 32'h0, 4'h0, 0, ok);
        wait_rsp(20, ok2);
        vectors++;
        if (!(ok && ok2)) begin miscompares++; $display("FAIL rd0_done: got %b%b expected 11", ok, ok2); end
        vectors++;
        if (got_data !== 32'hDEAD_BEEF || got_resp !== 2'b00) begin
            miscompares++; $display("FAIL rd0_data: got %h/%h expected deadbeef/0", got_data, got_resp);
        end
        vectors++;
        if (ar_first - acc_cyc != 1 || ar_last - acc_cyc != 1 || rsp_first - acc_cyc != 3) begin
            miscompares++;
            $display("FAIL rd0_timing: got ar %0d..%0d rsp %0d expected 1..1 rsp 3",
                     ar_first - acc_cyc, ar_last - acc_cyc, rsp_first - acc_cyc);
        end
        vectors++;
        if (cap_ar_addr !== 32'h8000_0000 || aw_first != -1) begin
            miscompares++; $display("FAIL rd0_addr: got %h aw_seen=%0d expected 80000000 -1", cap_ar_addr, aw_first);
        end
    endtask

    task automatic test_write_w_first();
        bit ok, ok2;
        set_dly(0, 3, 0, 0, 0, 0); cfg_resp = 2'b00; proto_err = 0;
        issue(1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 0, ok);
        wait_rsp(30, ok2);
        ref_mem[4][15:0] = 16'h5678;
        vectors++;
        if (!(ok && ok2) || got_data !== 32'h0 || got_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL wr_rsp: got ok=%b%b data=%h resp=%h expected 11/0/0", ok, ok2, got_data, got_resp);
        end
        vectors++;
        if (w_first - acc_cyc != 1 || w_last - acc_cyc != 1 || aw_first - acc_cyc != 1 ||
            aw_last - acc_cyc != 4 || b_first - acc_cyc != 5) begin
            miscompares++;
            $display("FAIL wr_timing: got w %0d..%0d aw %0d..%0d b %0d expected 1..1 1..4 5",
                     w_first - acc_cyc, w_last - acc_cyc, aw_first - acc_cyc, aw_last - acc_cyc, b_first - acc_cyc);
        end
        vectors++;
        if (cap_aw_addr !== 32'h8000_0010 || cap_w_data !== 32'h1234_5678 || cap_w_strb !== 4'b0011) begin
            miscompares++;
            $display("FAIL wr_fields: got %h %h %b expected 80000010 12345678 0011", cap_aw_addr, cap_w_data, cap_w_strb);
        end
        vectors++;
        if (mem[4] !== ref_mem[4] || proto_err != 0) begin
            miscompares++; $display("FAIL wr_mem: got %h perr=%0d expected %h 0", mem[4], proto_err, ref_mem[4]);
        end
    endtask

    task automatic test_backpressure();
        bit ok, ok2;
        set_dly(1, 0, 0, 2, 0, 5); cfg_resp = 2'b01; proto_err = 0;
        issue(0, 32'h8000_0014, 32'h0, 4'h0, 1, ok);
        wait_rsp(40, ok2);
        req_valid = 0;
        vectors++;
        if (!(ok && ok2) || got_data !== ref_mem[5] || got_resp !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_data: got ok=%b%b %h/%h expected 11 %h/1", ok, ok2, got_data, got_resp, ref_mem[5]);
        end
        vectors++;
        if (got_cyc - rsp_first != 5 || proto_err != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got wait=%0d perr=%0d expected 5 0", got_cyc - rsp_first, proto_err);
        end
        tick(); tick(); tick();
        vectors++;
        if (ar_hs != 1 || aw_hs != 0 || req_ready !== 1'b1 || ar_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ignore: got ar_hs=%0d aw_hs=%0d ready=%b ar=%b expected 1 0 1 0",
                     ar_hs, aw_hs, req_ready, ar_valid);
        end
    endtask

    task automatic test_error_resp();
        bit ok, ok2;
        set_dly(0, 1, 2, 0, 1, 0); cfg_resp = 2'b10; proto_err = 0;
        issue(1, 32'h8000_0020, 32'hCAFE_F00D, 4'b1111, 0, ok);
        wait_rsp(30, ok2);
        ref_mem[8] = 32'hCAFE_F00D;
        vectors++;
        if (!(ok && ok2) || got_resp !== 2'b10 || got_data !== 32'h0) begin
            miscompares++; $display("FAIL err_bresp: got %h/%h expected 2/0", got_resp, got_data);
        end
        cfg_resp = 2'b11;
        issue(0, 32'h8000_0020, 32'h0, 4'h0, 0, ok);
        wait_rsp(30, ok2);
        vectors++;
        if (!(ok && ok2) || got_resp !== 2'b11 || got_data !== 32'hCAFE_F00D || proto_err != 0) begin
            miscompares++; $display("FAIL err_rresp: got %h/%h expected 3/cafef00d", got_resp, got_data);
        end
    endtask

    task automatic test_random();
        bit ok, ok2, wr;
        int idx;
        logic [31:0] a, d, exp_d;
        logic [3:0] m;
        proto_err = 0;
        for (int t = 0; t < 40; t++) begin
            wr = 1'($urandom % 2); idx = int'($urandom % 16);
            a = 32'h8000_0000 | (idx << 2); d = $urandom; m = 4'($urandom % 16);
            set_dly($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                    $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
            cfg_resp = 2'($urandom % 4);
            exp_d = wr ? 32'h0 : ref_mem[idx];
            if (wr)
                for (int b = 0; b < 4; b++) if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
            issue(wr, a, d, m, 0, ok);
            wait_rsp(60, ok2);
            vectors++;
            if (!(ok && ok2) || got_data !== exp_d || got_resp !== cfg_resp) begin
                miscompares++;
                $display("FAIL rnd_rsp[%0d]: got ok=%b%b %h/%h expected 11 %h/%h", t, ok, ok2,
                         got_data, got_resp, exp_d, cfg_resp);
            end
            vectors++;
            if (wr ? (aw_hs != 1 || w_hs != 1 || b_hs != 1 || ar_hs != 0 ||
                      cap_aw_addr !== a || cap_w_data !== d || cap_w_strb !== m)
                   : (ar_hs != 1 || r_hs != 1 || aw_hs != 0 || w_hs != 0 || cap_ar_addr !== a)) begin
                miscompares++;
                $display("FAIL rnd_bus[%0d]: got hs ar%0d r%0d aw%0d w%0d b%0d addr %h/%h expected wr=%b addr %h",
                         t, ar_hs, r_hs, aw_hs, w_hs, b_hs, cap_ar_addr, cap_aw_addr, wr, a);
            end
        end
        vectors++;
        if (proto_err != 0) begin
            miscompares++; $display("FAIL rnd_protocol: got %0d violations expected 0", proto_err);
        end
    endtask

    task automatic test_timeout();
        bit ok, ok2;
        set_dly(1000, 0, 0, 0, 0, 0); cfg_resp = 2'b00; proto_err = 0;
        issue(0, 32'h8000_0004, 32'h0, 4'h0, 0, ok);
`ifdef AXI4_LITE_M_TIMEOUT_EN
        wait_rsp(40, ok2);
        tick(); tick();
        vectors++;
        if (!(ok && ok2) || ar_last - acc_cyc != TMO || ar_hs != 0) begin
            miscompares++;
            $display("FAIL tmo_ar: got ok=%b%b ar_last=%0d hs=%0d expected 11 %0d 0",
                     ok, ok2, ar_last - acc_cyc, ar_hs, TMO);
        end
        vectors++;
        if (to_cnt != 1 || to_cyc - acc_cyc != TMO + 1 || got_resp !== 2'b11 || got_data !== 32'h0) begin
            miscompares++;
            $display("FAIL tmo_rsp: got pulses=%0d at %0d resp=%h data=%h expected 1 at %0d 3 0",
                     to_cnt, to_cyc - acc_cyc, got_resp, got_data, TMO + 1);
        end
        set_dly(0, 0, 0, 0, 0, 0);
`else
        for (int i = 0; i < 99; i++) tick();
        vectors++;
        if (!ok || ar_hi != 100 || ar_valid !== 1'b1 || to_cnt != 0 || got) begin
            miscompares++;
            $display("FAIL notmo_hold: got ar_cycles=%0d ar=%b pulses=%0d rsp=%b expected 100 1 0 0",
                     ar_hi, ar_valid, to_cnt, got);
        end
        set_dly(0, 0, 0, 0, 0, 0);
        wait_rsp(20, ok2);
        vectors++;
        if (!ok2 || got_data !== ref_mem[1] || got_resp !== 2'b00 || proto_err != 0) begin
            miscompares++;
            $display("FAIL notmo_done: got %b %h/%h expected 1 %h/0", ok2, got_data, got_resp, ref_mem[1]);
        end
`endif
    endtask

    task automatic test_async_reset();
        bit ok, ok2;
        set_dly(0, 50, 50, 0, 0, 0); cfg_resp = 2'b00;
        issue(1, 32'h8000_0030, 32'hFFFF_FFFF, 4'hF, 0, ok);
        tick(); tick();
        #2 rst_n = 0;
        #1;
        vectors++;
        if (!ok || aw_valid !== 1'b0 || w_valid !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_drop: got ok=%b aw=%b w=%b ready=%b expected 1 0 0 1", ok, aw_valid, w_valid, req_ready);
        end
        sub_clear(); proto_err = 0;
        tick();
        rst_n = 1;
        tick(); tick();
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || got || mem[12] !== ref_mem[12]) begin
            miscompares++;
            $display("FAIL arst_after: got ready=%b rsp=%b got=%b mem=%h expected 1 0 0 %h",
                     req_ready, rsp_valid, got, mem[12], ref_mem[12]);
        end
        set_dly(0, 0, 0, 0, 0, 0);
        issue(0, 32'h8000_0030, 32'h0, 4'h0, 0, ok);
        wait_rsp(20, ok2);
        vectors++;
        if (!(ok && ok2) || got_data !== ref_mem[12] || proto_err != 0) begin
            miscompares++; $display("FAIL arst_recover: got %h expected %h", got_data, ref_mem[12]);
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_w_first();
        test_backpressure();
        test_error_resp();
        test_random();
        test_timeout();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
